word_swap_engine: RTL and testbench

//  Letter-store end of the game controller's word interface. Receives scramPls,

---
 rtl/word_swap_engine_pkg.sv | 66 ++++++
 rtl/word_swap_engine_if.sv | 28 ++
 rtl/word_swap_engine_rom.sv | 22 ++
 rtl/word_swap_engine.sv | 119 +++++++++++
 tb/tb_word_swap_engine.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/word_swap_engine_pkg.sv
`default_nettype none
// word_game_pkg: shared widths, letter codes, FSM encoding and word helpers.
// Revision: 1.0
package word_game_pkg;

  localparam int LETTER_W       = 5;
  localparam int MAX_LEN        = 8;
  localparam int IDX_W          = 3;
  localparam int WORDS_PER_LEN  = 4;
  localparam int PTR_W          = 2;
  localparam int SCRAMBLE_SWAPS = 8;
  localparam int SWAP_CNT_W     = $clog2(SCRAMBLE_SWAPS);
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  localparam logic [LETTER_W-1:0] L_BLANK = 5'd0;
  localparam logic [LETTER_W-1:0] L_A     = 5'd1;
  localparam logic [LETTER_W-1:0] L_Z     = 5'd26;

  typedef logic [MAX_LEN-1:0][LETTER_W-1:0] word_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [3:0] len_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SCRAMBLE = 3'd2,
    ST_FIXUP    = 3'd3,
    ST_READY    = 3'd4
  } state_e;

  function automatic len_t len_of(input logic [1:0] lett_num);
    case (lett_num)
      2'd0:    len_of = 4'd4;
      2'd1:    len_of = 4'd6;
      default: len_of = 4'd8;
    endcase
  endfunction

  function automatic idx_t idx_mod(input idx_t v, input len_t len);
    if (len == 4'd4)
      idx_mod = v & 3'd3;
    else if (len == 4'd6)
      idx_mod = (v >= 3'd6) ? v - 3'd6 : v;
    else
      idx_mod = v;
  endfunction

  function automatic word_t swap_letters(input word_t w, input idx_t a, input idx_t b);
    word_t r;
    r    = w;
    r[a] = w[b];
    r[b] = w[a];
    return r;
  endfunction

  // Upper-case ASCII carries the letter code in its low 5 bits; space maps to blank.
  function automatic word_t ascii_word(input logic [8*MAX_LEN-1:0] s);
    word_t r;
    r = '0;
    for (int i = 0; i < MAX_LEN; i++)
      r[i] = s[8*(MAX_LEN-1-i) +: LETTER_W];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_swap_engine_if.sv
`default_nettype none
// word_swap_engine_if: controller <-> letter-store request and status bundle.
// Revision: 1.0
interface word_swap_engine_if;
  import word_game_pkg::*;

  logic       scramPls;
  logic       flipPls;
  idx_t       ind1;
  idx_t       ind2;
  logic [1:0] lettNum;
  word_t      letters;
  len_t       wordLen;
  logic       busy;
  logic       isCorrect;
  logic [7:0] swapCount;

  modport master (
    output scramPls, flipPls, ind1, ind2, lettNum,
    input  letters, wordLen, busy, isCorrect, swapCount
  );

  modport slave (
    input  scramPls, flipPls, ind1, ind2, lettNum,
    output letters, wordLen, busy, isCorrect, swapCount
  );
endinterface
`default_nettype wire

// File: rtl/word_swap_engine_rom.sv
`default_nettype none
// word_rom: combinational (class, pointer) -> blank-padded target word lookup.
// Revision: 1.0
module word_rom
  import word_game_pkg::*;
(
  input  wire [1:0]       cls,
  input  wire [PTR_W-1:0] ptr,
  output word_t           word
);

  localparam word_t TABLE [4*WORDS_PER_LEN] = '{
    ascii_word("GAME    "), ascii_word("PLAY    "), ascii_word("WORD    "), ascii_word("SWAP    "),
    ascii_word("PUZZLE  "), ascii_word("LETTER  "), ascii_word("ANSWER  "), ascii_word("RANDOM  "),
    ascii_word("COMPUTER"), ascii_word("KEYBOARD"), ascii_word("SOFTWARE"), ascii_word("HARDWARE"),
    ascii_word("TERMINAL"), ascii_word("FUNCTION"), ascii_word("REGISTER"), ascii_word("CHAMPION")
  };

  assign word = TABLE[{cls, ptr}];

endmodule
`default_nettype wire

// File: rtl/word_swap_engine.sv
`default_nettype none
// word_swap_engine: loads a ROM word, LFSR-scrambles it and applies controller swaps.
// Optional macro SWAP_COUNT_EN keeps the accepted-flip counter.  Revision: 1.0
module word_swap_engine
  import word_game_pkg::*;
(
  input wire clk,
  input wire rst,
  word_swap_engine_if.slave bus
);

  localparam logic [SWAP_CNT_W-1:0] SWAP_LAST = SWAP_CNT_W'(SCRAMBLE_SWAPS - 1);

  state_e                state, state_nxt;
  logic [7:0]            lfsr;
  logic [1:0]            cls;
  logic [PTR_W-1:0]      ptr [4];
  word_t                 letters, target, rom_word;
  len_t                  word_len;
  logic [SWAP_CNT_W-1:0] swap_idx;
  logic                  busy, is_correct, start, flip_ok;
  idx_t                  sa, sb;

  word_rom u_rom (
    .cls  (cls),
    .ptr  (ptr[cls]),
    .word (rom_word)
  );

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign start   = bus.scramPls && (state == ST_IDLE || state == ST_READY);
  // scramPls has priority, so a coincident flip is never accepted
  assign flip_ok = bus.flipPls && !bus.scramPls && (state == ST_READY) &&
                   ({1'b0, bus.ind1} < word_len) && ({1'b0, bus.ind2} < word_len) &&
                   (bus.ind1 != bus.ind2);
  assign sa      = idx_mod(lfsr[2:0], word_len);
  assign sb      = idx_mod(lfsr[5:3], word_len);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_READY: if (start) state_nxt = ST_LOAD;
      ST_LOAD:           state_nxt = ST_SCRAMBLE;
      ST_SCRAMBLE:       if (swap_idx == SWAP_LAST) state_nxt = ST_FIXUP;
      ST_FIXUP:          state_nxt = ST_READY;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    is_correct = 1'b0;
    case (state)
      ST_LOAD, ST_SCRAMBLE, ST_FIXUP: busy = 1'b1;
      ST_READY:                       is_correct = (letters == target);
      default:                        ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      letters  <= '0;
      target   <= '0;
      word_len <= '0;
      cls      <= '0;
      swap_idx <= '0;
      for (int i = 0; i < 4; i++) ptr[i] <= '0;
    end else begin
      if (start) cls <= bus.lettNum;
      case (state)
        ST_LOAD: begin
          letters  <= rom_word;
          target   <= rom_word;
          word_len <= len_of(cls);
          ptr[cls] <= ptr[cls] + 1'b1;
          swap_idx <= '0;
        end
        ST_SCRAMBLE: begin
          letters  <= swap_letters(letters, sa, sb);
          swap_idx <= swap_idx + 1'b1;
        end
        // Never hand the player an already-solved word; letter0 != letter1 in ROM
        ST_FIXUP: if (letters == target) letters <= swap_letters(letters, 3'd0, 3'd1);
        ST_READY: if (flip_ok) letters <= swap_letters(letters, bus.ind1, bus.ind2);
        default:  ;
      endcase
    end
  end

`ifdef SWAP_COUNT_EN
  logic [7:0] swap_count;

  always_ff @(posedge clk) begin
    if (rst)                               swap_count <= '0;
    else if (state == ST_LOAD)             swap_count <= '0;
    else if (flip_ok && swap_count != '1)  swap_count <= swap_count + 1'b1;
  end

  assign bus.swapCount = swap_count;
`else
  assign bus.swapCount = 8'd0;
`endif

  assign bus.letters   = letters;
  assign bus.wordLen   = word_len;
  assign bus.busy      = busy;
  assign bus.isCorrect = is_correct;

endmodule
`default_nettype wire

// File: tb/tb_word_swap_engine.sv
`default_nettype none
// tb_word_swap_engine: directed bench for load/scramble, flips, dropped requests and reset.
module tb_word_swap_engine;

  typedef logic [7:0][4:0] tw_t;

  // Hand-encoded words, letter 0 in the LSBs (A=1 .. Z=26, blank=0)
  localparam tw_t GAME_W   = {5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd13, 5'd1, 5'd7};
  localparam tw_t PLAY_W   = {5'd0, 5'd0, 5'd0, 5'd0, 5'd25, 5'd1, 5'd12, 5'd16};
  localparam tw_t PUZZLE_W = {5'd0, 5'd0, 5'd5, 5'd12, 5'd26, 5'd26, 5'd21, 5'd16};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  word_swap_engine_if bus ();

  word_swap_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] m_lfsr;
  tw_t        m_word, m_target;
  int         m_count;
  int         n_tests = 0;
  int         n_fail  = 0;

  always @(posedge clk)
    m_lfsr <= rst ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  function automatic logic [2:0] m_mod(input logic [2:0] v, input int len);
    if (len == 4) return {1'b0, v[1:0]};
    if (len == 6 && v >= 3'd6) return v - 3'd6;
    return v;
  endfunction

  function automatic tw_t m_swap(input tw_t w, input int a, input int b);
    tw_t r;
    r    = w;
    r[a] = w[b];
    r[b] = w[a];
    return r;
  endfunction

  function automatic int exp_cnt(input int n);
`ifdef SWAP_COUNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_flip(input int a, input int b);
    bus.flipPls = 1'b1;
    bus.ind1    = a[2:0];
    bus.ind2    = b[2:0];
    tick();
    bus.flipPls = 1'b0;
  endtask

  task automatic do_scramble(input logic [1:0] cls, input tw_t src, input int len,
                             input bit with_flip, input bit flip_in_busy);
    int busy_cnt;
    busy_cnt     = 0;
    bus.scramPls = 1'b1;
    bus.lettNum  = cls;
    if (with_flip) begin
      bus.flipPls = 1'b1; bus.ind1 = 3'd0; bus.ind2 = 3'd1;
    end
    tick();
    bus.scramPls = 1'b0;
    bus.flipPls  = 1'b0;
    busy_cnt += int'(bus.busy);
    n_tests++;
    if (bus.isCorrect !== 1'b0) begin
      n_fail++; $display("FAIL start_iscorrect: got %b expected 0", bus.isCorrect);
    end
    if (flip_in_busy) begin
      bus.flipPls = 1'b1; bus.ind1 = 3'd0; bus.ind2 = 3'd1;
    end
    tick();
    bus.flipPls = 1'b0;
    busy_cnt += int'(bus.busy);
    m_word   = src;
    m_target = src;
    for (int k = 0; k < 8; k++) begin
      m_word = m_swap(m_word, m_mod(m_lfsr[2:0], len), m_mod(m_lfsr[5:3], len));
      if (flip_in_busy && k == 3) begin
        bus.flipPls = 1'b1; bus.ind1 = 3'd2; bus.ind2 = 3'd3;
      end
      tick();
      bus.flipPls = 1'b0;
      busy_cnt += int'(bus.busy);
    end
    if (m_word == m_target) m_word = m_swap(m_word, 0, 1);
    tick();
    busy_cnt += int'(bus.busy);
    m_count = 0;
    n_tests++;
    if (busy_cnt !== 10) begin
      n_fail++; $display("FAIL busy_cycles: got %0d expected 10", busy_cnt);
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL ready_busy: got %b expected 0", bus.busy);
    end
    n_tests++;
    if (bus.wordLen !== 4'(len)) begin
      n_fail++; $display("FAIL word_len: got %0d expected %0d", bus.wordLen, len);
    end
    n_tests++;
    if (bus.letters !== m_word) begin
      n_fail++; $display("FAIL scrambled: got %h expected %h", bus.letters, m_word);
    end
    n_tests++;
    if (bus.letters === src) begin
      n_fail++; $display("FAIL not_solved: got %h required different from %h", bus.letters, src);
    end
    n_tests++;
    if (bus.isCorrect !== 1'b0 || bus.swapCount !== 8'd0) begin
      n_fail++; $display("FAIL ready_status: got isCorrect=%b swapCount=%0d expected 0/0",
                         bus.isCorrect, bus.swapCount);
    end
  endtask

  task automatic check_idle(input string tag);
    n_tests++;
    if (bus.letters !== '0 || bus.wordLen !== 4'd0 || bus.busy !== 1'b0 ||
        bus.isCorrect !== 1'b0 || bus.swapCount !== 8'd0) begin
      n_fail++;
      $display("FAIL %s: got letters=%h len=%0d busy=%b ok=%b cnt=%0d expected all zero",
               tag, bus.letters, bus.wordLen, bus.busy, bus.isCorrect, bus.swapCount);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_idle("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_scramble_len4();
    do_scramble(2'd0, GAME_W, 4, 1'b0, 1'b0);
  endtask

  task automatic test_restore();
    int nflips;
    nflips = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_word[i] != m_target[i]) begin
        int j;
        j = i + 1;
        while (j < 4 && m_word[j] != m_target[i]) j++;
        do_flip(i, j);
        m_word = m_swap(m_word, i, j);
        nflips++;
        m_count++;
        n_tests++;
        if (bus.letters !== m_word || bus.isCorrect !== (m_word == m_target)) begin
          n_fail++; $display("FAIL restore_step: got %h ok=%b expected %h ok=%b",
                             bus.letters, bus.isCorrect, m_word, (m_word == m_target));
        end
      end
    end
    n_tests++;
    if (bus.isCorrect !== 1'b1 || bus.letters !== GAME_W) begin
      n_fail++; $display("FAIL restored: got %h ok=%b expected %h ok=1",
                         bus.letters, bus.isCorrect, GAME_W);
    end
    n_tests++;
    if (bus.swapCount !== 8'(exp_cnt(nflips))) begin
      n_fail++; $display("FAIL restore_count: got %0d expected %0d", bus.swapCount, exp_cnt(nflips));
    end
    do_flip(0, 1);
    m_word = m_swap(m_word, 0, 1);
    m_count++;
    n_tests++;
    if (bus.isCorrect !== 1'b0 || bus.letters !== m_word ||
        bus.swapCount !== 8'(exp_cnt(m_count))) begin
      n_fail++; $display("FAIL extra_flip: got %h ok=%b cnt=%0d expected %h ok=0 cnt=%0d",
                         bus.letters, bus.isCorrect, bus.swapCount, m_word, exp_cnt(m_count));
    end
  endtask

  task automatic test_ignored_flips();
    do_flip(5, 1);
    do_flip(2, 2);
    do_flip(4, 0);
    n_tests++;
    if (bus.letters !== m_word || bus.swapCount !== 8'(exp_cnt(m_count))) begin
      n_fail++; $display("FAIL ignored_flips: got %h cnt=%0d expected %h cnt=%0d",
                         bus.letters, bus.swapCount, m_word, exp_cnt(m_count));
    end
    do_flip(3, 0);
    m_word = m_swap(m_word, 3, 0);
    m_count++;
    n_tests++;
    if (bus.letters !== m_word || bus.swapCount !== 8'(exp_cnt(m_count))) begin
      n_fail++; $display("FAIL edge_flip: got %h cnt=%0d expected %h cnt=%0d",
                         bus.letters, bus.swapCount, m_word, exp_cnt(m_count));
    end
  endtask

  task automatic test_len6();
    do_scramble(2'd1, PUZZLE_W, 6, 1'b0, 1'b0);
    do_flip(6, 0);
    n_tests++;
    if (bus.letters !== m_word || bus.swapCount !== 8'd0) begin
      n_fail++; $display("FAIL len6_ignored: got %h cnt=%0d expected %h cnt=0",
                         bus.letters, bus.swapCount, m_word);
    end
    do_flip(5, 0);
    m_word = m_swap(m_word, 5, 0);
    m_count++;
    n_tests++;
    if (bus.letters !== m_word || bus.swapCount !== 8'(exp_cnt(m_count))) begin
      n_fail++; $display("FAIL len6_flip: got %h cnt=%0d expected %h cnt=%0d",
                         bus.letters, bus.swapCount, m_word, exp_cnt(m_count));
    end
  endtask

  task automatic test_simultaneous();
    // class0 pointer has advanced once, so PLAY is next; flips during busy must vanish
    do_scramble(2'd0, PLAY_W, 4, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    bus.scramPls = 1'b1;
    bus.lettNum  = 2'd0;
    tick();
    bus.scramPls = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_idle("mid_reset_state");
    rst = 1'b0;
    do_scramble(2'd0, GAME_W, 4, 1'b0, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.scramPls = 1'b0;
    bus.flipPls  = 1'b0;
    bus.ind1     = 3'd0;
    bus.ind2     = 3'd0;
    bus.lettNum  = 2'd0;
    @(negedge clk);
    test_reset();
    test_scramble_len4();
    test_restore();
    test_ignored_flips();
    test_len6();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
